// File: rtl/simple_pkg.sv
// Shared constants and types for the phase sequencer.
package simple_pkg;

  localparam int PHASE_IDLE     = 0;
  localparam int NUM_PHASES_DEF = 5;
  localparam int PHASE_W_DEF    = 3;

  typedef enum logic [0:0] {
    MODE_RUN  = 1'b0,
    MODE_STEP = 1'b1
  } run_mode_e;

endpackage

// File: rtl/rise_edge.sv
// Registered rising-edge detector; history resets to 1 so a level held
// through reset is not seen as an edge.
module rise_edge (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic pulse
);

  logic hist_q;
  logic hist_d;
  logic pulse_q;
  logic pulse_d;

  // Next-state for history and edge pulse.
  always_comb begin
    hist_d  = d;
    pulse_d = d & ~hist_q;
  end

  // History and pulse registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      hist_q  <= 1'b1;
      pulse_q <= 1'b0;
    end else begin
      hist_q  <= hist_d;
      pulse_q <= pulse_d;
    end
  end

  assign pulse = pulse_q;

endmodule

// File: rtl/phase_sequencer.sv
// Multi-cycle phase sequencer with run/step, halt, stall and retire counter.
// Optional breakpoint compare is built when SIMPLE_BREAKPOINT_EN is defined.
module phase_sequencer
  import simple_pkg::*;
#(
  parameter int NUM_PHASES = NUM_PHASES_DEF,
  parameter int PHASE_W    = PHASE_W_DEF,
  parameter int CNT_W      = 16,
  parameter int PC_W       = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  exec,
  input  logic                  step,
  input  logic                  hlt,
  input  logic                  stall,
  input  logic [PC_W-1:0]       pc,
  input  logic [PC_W-1:0]       bp_addr,
  output logic [PHASE_W-1:0]    phase,
  output logic [NUM_PHASES:0]   phase_oh,
  output logic                  executing,
  output logic                  instr_done,
  output logic [CNT_W-1:0]      instr_count,
  output logic                  bp_hit
);

  localparam logic [PHASE_W-1:0] PH_IDLE  = PHASE_W'(PHASE_IDLE);
  localparam logic [PHASE_W-1:0] PH_FIRST = PHASE_W'(1);
  localparam logic [PHASE_W-1:0] PH_LAST  = PHASE_W'(NUM_PHASES);

  logic               exec_p;
  logic               step_p;
  logic               start_s;
  logic               stop_req_s;
  logic               bp_match_s;
  run_mode_e          mode_s;

  logic [PHASE_W-1:0] phase_q;
  logic [PHASE_W-1:0] phase_d;
  logic               stop_q;
  logic               stop_d;
  logic               done_q;
  logic               done_d;
  logic [CNT_W-1:0]   cnt_q;
  logic [CNT_W-1:0]   cnt_d;
  logic [NUM_PHASES:0] phase_oh_s;

  rise_edge u_exec_edge (
    .clk   (clk),
    .rst   (rst),
    .d     (exec),
    .pulse (exec_p)
  );

  rise_edge u_step_edge (
    .clk   (clk),
    .rst   (rst),
    .d     (step),
    .pulse (step_p)
  );

  assign start_s    = exec_p | step_p;
  assign mode_s     = exec_p ? MODE_RUN : MODE_STEP;
  assign stop_req_s = exec_p | hlt | bp_match_s;

`ifdef SIMPLE_BREAKPOINT_EN
  logic bp_hit_q;
  logic bp_hit_d;

  // The compare is only meaningful on the first phase of an instruction.
  assign bp_match_s = (phase_q == PH_FIRST) && (pc == bp_addr);

  // Sticky hit flag, cleared by the next start from idle.
  always_comb begin
    bp_hit_d = bp_hit_q;
    if (phase_q == PH_IDLE) begin
      if (start_s) begin
        bp_hit_d = 1'b0;
      end else begin
        bp_hit_d = bp_hit_q;
      end
    end else if (bp_match_s) begin
      bp_hit_d = 1'b1;
    end else begin
      bp_hit_d = bp_hit_q;
    end
  end

  // Breakpoint flag register.
  always_ff @(posedge clk) begin
    if (rst) begin
      bp_hit_q <= 1'b0;
    end else begin
      bp_hit_q <= bp_hit_d;
    end
  end

  assign bp_hit = bp_hit_q;
`else
  logic unused_bp_s;
  assign unused_bp_s = ^{pc, bp_addr};
  assign bp_match_s  = 1'b0;
  assign bp_hit      = 1'b0;
`endif

  // Phase advance, deferred stop and retirement bookkeeping.
  always_comb begin
    phase_d = phase_q;
    stop_d  = stop_q;
    done_d  = 1'b0;
    cnt_d   = cnt_q;
    if (phase_q == PH_IDLE) begin
      if (start_s) begin
        phase_d = PH_FIRST;
        stop_d  = (mode_s == MODE_STEP);
      end else begin
        phase_d = phase_q;
        stop_d  = stop_q;
      end
    end else if (stall) begin
      stop_d = stop_q | stop_req_s;
    end else if (phase_q != PH_LAST) begin
      phase_d = phase_q + PHASE_W'(1);
      stop_d  = stop_q | stop_req_s;
    end else begin
      done_d = 1'b1;
      cnt_d  = cnt_q + CNT_W'(1);
      if (stop_q | stop_req_s) begin
        phase_d = PH_IDLE;
        stop_d  = 1'b0;
      end else begin
        phase_d = PH_FIRST;
        stop_d  = 1'b0;
      end
    end
  end

  // Sequencer state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q <= PH_IDLE;
      stop_q  <= 1'b0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      phase_q <= phase_d;
      stop_q  <= stop_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
    end
  end

  // One-hot decode straight from the phase register.
  always_comb begin
    phase_oh_s = '0;
    for (int i = 0; i <= NUM_PHASES; i++) begin
      phase_oh_s[i] = (phase_q == PHASE_W'(i));
    end
  end

  assign phase       = phase_q;
  assign phase_oh    = phase_oh_s;
  assign executing   = (phase_q != PH_IDLE);
  assign instr_done  = done_q;
  assign instr_count = cnt_q;

endmodule

// File: tb/tb_phase_sequencer.sv
// Self-checking bench for phase_sequencer; exercises the breakpoint path
// as well when SIMPLE_BREAKPOINT_EN is defined.
module tb_phase_sequencer;

  localparam int NP  = 5;
  localparam int NP7 = 7;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        exec = 1'b0;
  logic        step = 1'b0;
  logic        hlt = 1'b0;
  logic        stall = 1'b0;
  logic [15:0] pc = 16'h0000;
  logic [15:0] bp_addr = 16'h0004;

  logic [2:0]  phase;
  logic [NP:0] phase_oh;
  logic        executing;
  logic        instr_done;
  logic [15:0] instr_count;
  logic        bp_hit;

  logic [2:0]   phase7;
  logic [NP7:0] phase_oh7;
  logic         executing7;
  logic         instr_done7;
  logic [15:0]  instr_count7;
  logic         bp_hit7;

  int total = 0;
  int bad = 0;
  bit chk_en = 1'b0;

  phase_sequencer #(.NUM_PHASES(NP), .PHASE_W(3), .CNT_W(16), .PC_W(16)) dut (
    .clk(clk), .rst(rst), .exec(exec), .step(step), .hlt(hlt), .stall(stall),
    .pc(pc), .bp_addr(bp_addr), .phase(phase), .phase_oh(phase_oh),
    .executing(executing), .instr_done(instr_done), .instr_count(instr_count),
    .bp_hit(bp_hit)
  );

  phase_sequencer #(.NUM_PHASES(NP7), .PHASE_W(3), .CNT_W(16), .PC_W(16)) dut7 (
    .clk(clk), .rst(rst), .exec(exec), .step(step), .hlt(hlt), .stall(stall),
    .pc(pc), .bp_addr(bp_addr), .phase(phase7), .phase_oh(phase_oh7),
    .executing(executing7), .instr_done(instr_done7), .instr_count(instr_count7),
    .bp_hit(bp_hit7)
  );

  always #5 clk = ~clk;

  // Behavioural model of the NP=5 instance.
  int m_phase = 0;
  bit m_stop = 1'b0;
  int m_cnt = 0;
  bit m_done = 1'b0;
  bit m_bp = 1'b0;
  bit m_ex_prev = 1'b1;
  bit m_st_prev = 1'b1;
  bit m_ex_pend = 1'b0;
  bit m_st_pend = 1'b0;
  bit go_run, go_step, bpm, req;

  always @(posedge clk) begin
    if (rst) begin
      m_phase = 0; m_stop = 0; m_cnt = 0; m_done = 0; m_bp = 0;
      m_ex_prev = 1; m_st_prev = 1; m_ex_pend = 0; m_st_pend = 0;
    end else begin
      go_run  = m_ex_pend;
      go_step = m_st_pend;
      m_ex_pend = exec && !m_ex_prev;
      m_st_pend = step && !m_st_prev;
      m_ex_prev = exec;
      m_st_prev = step;
`ifdef SIMPLE_BREAKPOINT_EN
      bpm = (m_phase == 1) && (pc == bp_addr);
`else
      bpm = 1'b0;
`endif
      m_done = 0;
      if (m_phase == 0) begin
        if (go_run || go_step) begin
          m_phase = 1;
          m_stop = !go_run;
          m_bp = 0;
        end
      end else begin
        req = go_run || hlt || bpm;
        if (bpm) m_bp = 1;
        if (stall) m_stop = m_stop || req;
        else if (m_phase < NP) begin
          m_phase = m_phase + 1;
          m_stop = m_stop || req;
        end else begin
          m_done = 1;
          m_cnt = (m_cnt + 1) % 65536;
          m_phase = (m_stop || req) ? 0 : 1;
          m_stop = 0;
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("phase", 32'(phase), 32'(m_phase));
      chk("phase_oh", 32'(phase_oh), 32'(1) << m_phase);
      chk("executing", 32'(executing), 32'(m_phase != 0));
      chk("instr_done", 32'(instr_done), 32'(m_done));
      chk("instr_count", 32'(instr_count), 32'(m_cnt));
      chk("bp_hit", 32'(bp_hit), 32'(m_bp));
    end
  end

  task automatic wait_phase(input int p, input int budget);
    int n = 0;
    while (phase !== 3'(p) && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("wait_phase", 32'(phase), 32'(p));
  endtask

  int exp5 [9] = '{0, 1, 2, 3, 4, 5, 1, 2, 3};
  int exp7 [9] = '{0, 1, 2, 3, 4, 5, 6, 7, 1};
  int exps [7] = '{0, 1, 2, 3, 4, 5, 0};

  initial begin
    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    chk("rst_phase", 32'(phase), 32'd0);
    chk("rst_oh", 32'(phase_oh), 32'd1);
    chk("rst_exec", 32'(executing), 32'd0);
    chk("rst_done", 32'(instr_done), 32'd0);
    chk("rst_cnt", 32'(instr_count), 32'd0);
    chk("rst_bp", 32'(bp_hit), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Run, then a second exec pulse while in phase 3.
    exec = 1'b1;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      chk("run_seq", 32'(phase), 32'(exp5[i]));
      chk("run_seq7", 32'(phase7), 32'(exp7[i]));
      if (i == 7) exec = 1'b0;
      if (i == 8) exec = 1'b1;
    end
    @(negedge clk); chk("stop_p4", 32'(phase), 32'd4);
    @(negedge clk); chk("stop_p5", 32'(phase), 32'd5);
    @(negedge clk); chk("stop_p0", 32'(phase), 32'd0);
    chk("stop_done", 32'(instr_done), 32'd1);
    chk("stop_cnt", 32'(instr_count), 32'd2);

    // Single step from idle.
    exec = 1'b0;
    @(negedge clk);
    step = 1'b1;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      chk("step_seq", 32'(phase), 32'(exps[i]));
      if (i == 5) chk("step_exec_p5", 32'(executing), 32'd1);
    end
    chk("step_exec_off", 32'(executing), 32'd0);
    chk("step_cnt", 32'(instr_count), 32'd3);
    step = 1'b0;

    // Stall in phase 2 for 3 clocks, then at phase 5.
    exec = 1'b1;
    wait_phase(2, 20);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_p2", 32'(phase), 32'd2);
      chk("stall_cnt", 32'(instr_count), 32'd3);
    end
    stall = 1'b0;
    @(negedge clk); chk("stall_rel", 32'(phase), 32'd3);
    wait_phase(5, 10);
    stall = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk("stall_p5", 32'(phase), 32'd5);
      chk("stall_p5_done", 32'(instr_done), 32'd0);
    end
    stall = 1'b0;
    @(negedge clk);
    chk("stall_p5_rel_done", 32'(instr_done), 32'd1);
    chk("stall_p5_rel_ph", 32'(phase), 32'd1);
    chk("stall_p5_cnt", 32'(instr_count), 32'd4);

    // One-cycle halt in phase 2 finishes the instruction, then idles.
    wait_phase(2, 10);
    hlt = 1'b1;
    @(negedge clk); hlt = 1'b0; chk("hlt_p3", 32'(phase), 32'd3);
    @(negedge clk); chk("hlt_p4", 32'(phase), 32'd4);
    @(negedge clk); chk("hlt_p5", 32'(phase), 32'd5);
    @(negedge clk); chk("hlt_p0", 32'(phase), 32'd0);
    chk("hlt_cnt", 32'(instr_count), 32'd5);

    // Reset mid-instruction with exec held high across release.
    exec = 1'b0;
    @(negedge clk);
    exec = 1'b1;
    wait_phase(3, 10);
    rst = 1'b1;
    @(negedge clk);
    chk("rst3_phase", 32'(phase), 32'd0);
    chk("rst3_cnt", 32'(instr_count), 32'd0);
    chk("rst3_done", 32'(instr_done), 32'd0);
    rst = 1'b0;
    repeat (4) begin
      @(negedge clk);
      chk("held_exec_idle", 32'(phase), 32'd0);
    end
    exec = 1'b0;
    @(negedge clk);

`ifdef SIMPLE_BREAKPOINT_EN
    pc = 16'h0004;
    exec = 1'b1;
    wait_phase(2, 10);
    chk("bp_set", 32'(bp_hit), 32'd1);
    wait_phase(0, 20);
    chk("bp_stop_cnt", 32'(instr_count), 32'd1);
    chk("bp_sticky", 32'(bp_hit), 32'd1);
    pc = 16'h0000;
    exec = 1'b0;
    @(negedge clk);
    exec = 1'b1;
    repeat (2) @(negedge clk);
    chk("bp_clear", 32'(bp_hit), 32'd0);
    chk("bp_resume", 32'(phase), 32'd1);
    hlt = 1'b1;
    @(negedge clk);
    hlt = 1'b0;
    wait_phase(0, 20);
    exec = 1'b0;
`endif

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
